// File: rtl/rx_driver_if.sv
// Receive handshake bundle between the UART receiver and rx_driver.
// The receiver (master) presents a byte on RxData with RxReady and
// holds it until it sees RxAck; the driver (slave) answers with RxAck.
interface rx_driver_if;
  logic       RxReady;
  logic [7:0] RxData;
  logic       RxAck;

  modport master (
    output RxReady,
    output RxData,
    input  RxAck
  );

  modport slave (
    input  RxReady,
    input  RxData,
    output RxAck
  );
endinterface

// File: rtl/rx_driver.sv
// rx_driver: collects bytes from the UART receiver into a byte buffer.
// A message closes on the terminator byte, on a full buffer, or after an
// inter-byte idle timeout; the buffer then stays frozen and readable
// until the host pulses MsgClear.
module rx_driver #(
  parameter int          DEPTH_LOG2     = 8,
  parameter logic [7:0]  TERM_CHAR      = 8'h0D,
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd0
) (
  input  logic                  Clock,
  input  logic                  Reset,
  rx_driver_if.slave            rx,
  input  logic                  MsgClear,
  output logic                  MsgDone,
  output logic [DEPTH_LOG2:0]   MsgLen,
  output logic                  Overflow,
  output logic                  TimedOut,
  input  logic [DEPTH_LOG2-1:0] RdAddr,
  output logic [7:0]            RdData
);

  localparam int DEPTH = 2 ** DEPTH_LOG2;

  localparam logic [DEPTH_LOG2:0]   LEN_ZERO = {(DEPTH_LOG2+1){1'b0}};
  localparam logic [DEPTH_LOG2:0]   LEN_ONE  = {{DEPTH_LOG2{1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0]   LEN_FULL = {1'b1, {DEPTH_LOG2{1'b0}}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ZERO = {DEPTH_LOG2{1'b0}};
  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [15:0]           CNT_ZERO = 16'd0;
  localparam logic [15:0]           CNT_ONE  = 16'd1;

  typedef enum logic [1:0] {
    RX_IDLE = 2'b00,
    RX_ACK  = 2'b01,
    RX_DONE = 2'b10
  } rx_state_t;

  rx_state_t             state_r,     state_s;
  logic                  ack_r,       ack_s;
  logic                  done_r,      done_s;
  logic [DEPTH_LOG2:0]   len_r,       len_s;
  logic                  ovf_r,       ovf_s;
  logic                  to_r,        to_s;
  logic [DEPTH_LOG2-1:0] wr_ptr_r,    wr_ptr_s;
  logic [15:0]           idle_cnt_r,  idle_cnt_s;
  logic [7:0]            last_byte_r, last_byte_s;
  logic                  wr_en_s;
  logic [DEPTH_LOG2:0]   len_inc_s;
  logic [15:0]           cnt_inc_s;
  logic [7:0]            rd_data_r;

  logic [7:0] mem [0:DEPTH-1];

  // Next-state and next-output logic for the receive handshake FSM.
  always_comb begin
    state_s     = state_r;
    ack_s       = ack_r;
    done_s      = done_r;
    len_s       = len_r;
    ovf_s       = ovf_r;
    to_s        = to_r;
    wr_ptr_s    = wr_ptr_r;
    idle_cnt_s  = idle_cnt_r;
    last_byte_s = last_byte_r;
    wr_en_s     = 1'b0;
    len_inc_s   = len_r + LEN_ONE;
    cnt_inc_s   = idle_cnt_r + CNT_ONE;

    case (state_r)
      RX_IDLE: begin
        ack_s = 1'b0;
        if (rx.RxReady) begin
          // A new byte always wins over an idle timeout on the same edge.
          wr_en_s     = 1'b1;
          last_byte_s = rx.RxData;
          ack_s       = 1'b1;
          idle_cnt_s  = CNT_ZERO;
          state_s     = RX_ACK;
        end else if ((len_r != LEN_ZERO) && (TIMEOUT_CYCLES != CNT_ZERO)) begin
          if (cnt_inc_s == TIMEOUT_CYCLES) begin
            to_s       = 1'b1;
            done_s     = 1'b1;
            idle_cnt_s = CNT_ZERO;
            state_s    = RX_DONE;
          end else begin
            idle_cnt_s = cnt_inc_s;
          end
        end else begin
          idle_cnt_s = CNT_ZERO;
        end
      end

      RX_ACK: begin
        if (!rx.RxReady) begin
          ack_s    = 1'b0;
          wr_ptr_s = wr_ptr_r + PTR_ONE;
          len_s    = len_inc_s;
          // Termination is checked first so a terminator in the last slot
          // does not count as an overflow.
          if (last_byte_r == TERM_CHAR) begin
            done_s  = 1'b1;
            state_s = RX_DONE;
          end else if (len_inc_s == LEN_FULL) begin
            ovf_s   = 1'b1;
            done_s  = 1'b1;
            state_s = RX_DONE;
          end else begin
            state_s = RX_IDLE;
          end
        end else begin
          ack_s = 1'b1;
        end
      end

      RX_DONE: begin
        ack_s  = 1'b0;
        done_s = 1'b1;
        if (MsgClear) begin
          wr_ptr_s   = PTR_ZERO;
          len_s      = LEN_ZERO;
          done_s     = 1'b0;
          ovf_s      = 1'b0;
          to_s       = 1'b0;
          idle_cnt_s = CNT_ZERO;
          state_s    = RX_IDLE;
        end else begin
          state_s = RX_DONE;
        end
      end

      default: begin
        state_s     = RX_IDLE;
        ack_s       = 1'b0;
        done_s      = 1'b0;
        len_s       = LEN_ZERO;
        ovf_s       = 1'b0;
        to_s        = 1'b0;
        wr_ptr_s    = PTR_ZERO;
        idle_cnt_s  = CNT_ZERO;
        last_byte_s = 8'h00;
      end
    endcase
  end

  // State and registered-output update; Reset overrides every input.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state_r     <= RX_IDLE;
      ack_r       <= 1'b0;
      done_r      <= 1'b0;
      len_r       <= LEN_ZERO;
      ovf_r       <= 1'b0;
      to_r        <= 1'b0;
      wr_ptr_r    <= PTR_ZERO;
      idle_cnt_r  <= CNT_ZERO;
      last_byte_r <= 8'h00;
    end else begin
      state_r     <= state_s;
      ack_r       <= ack_s;
      done_r      <= done_s;
      len_r       <= len_s;
      ovf_r       <= ovf_s;
      to_r        <= to_s;
      wr_ptr_r    <= wr_ptr_s;
      idle_cnt_r  <= idle_cnt_s;
      last_byte_r <= last_byte_s;
    end
  end

  // Buffer write port; contents deliberately survive Reset.
  always_ff @(posedge Clock) begin
    if (wr_en_s && !Reset) begin
      mem[wr_ptr_r] <= rx.RxData;
    end
  end

  // Registered buffer read port, one-cycle latency in every state.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      rd_data_r <= 8'h00;
    end else begin
      rd_data_r <= mem[RdAddr];
    end
  end

  assign rx.RxAck = ack_r;
  assign MsgDone  = done_r;
  assign MsgLen   = len_r;
  assign Overflow = ovf_r;
  assign TimedOut = to_r;
  assign RdData   = rd_data_r;

endmodule

// File: tb/tb_rx_driver.sv
// Self-checking bench for rx_driver: directed handshake/boundary cases
// followed by random messages checked against a byte-queue model.
module tb_rx_driver;

  localparam int          DEPTH_LOG2 = 4;
  localparam int          DEPTH      = 16;
  localparam logic [7:0]  TERM       = 8'h0D;
  localparam int          TMO        = 20;

  logic                  clk;
  logic                  rst;
  logic                  msg_clear;
  logic                  msg_done;
  logic [DEPTH_LOG2:0]   msg_len;
  logic                  overflow;
  logic                  timed_out;
  logic [DEPTH_LOG2-1:0] rd_addr;
  logic [7:0]            rd_data;

  int n_tests;
  int n_fail;

  rx_driver_if rx();

  rx_driver #(
    .DEPTH_LOG2    (DEPTH_LOG2),
    .TERM_CHAR     (TERM),
    .TIMEOUT_CYCLES(16'd20)
  ) dut (
    .Clock   (clk),
    .Reset   (rst),
    .rx      (rx),
    .MsgClear(msg_clear),
    .MsgDone (msg_done),
    .MsgLen  (msg_len),
    .Overflow(overflow),
    .TimedOut(timed_out),
    .RdAddr  (rd_addr),
    .RdData  (rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    if (obs !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Receiver model: present byte, wait for RxAck, drop RxReady, wait for
  // RxAck to fall. Called at a negedge; returns at a negedge.
  task automatic send_byte(input logic [7:0] b);
    logic seen;
    rx.RxReady = 1'b1;
    rx.RxData  = b;
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = rx.RxAck;
    end
    check_value("ack_rise", 32'(seen), 32'd1);
    rx.RxReady = 1'b0;
    seen = 1'b1;
    for (int k = 0; k < 20 && seen; k++) begin
      @(negedge clk);
      seen = rx.RxAck;
    end
    check_value("ack_fall", 32'(seen), 32'd0);
  endtask

  task automatic read_check(input string tag, input int addr, input logic [7:0] expv);
    rd_addr = DEPTH_LOG2'(addr);
    @(negedge clk);
    check_value(tag, 32'(rd_data), 32'(expv));
  endtask

  task automatic pulse_clear();
    msg_clear = 1'b1;
    @(negedge clk);
    msg_clear = 1'b0;
  endtask

  logic [7:0] exp_q[$];
  logic       m_done, m_ovf, m_to;
  logic       ack_seen;
  logic [7:0] b;
  int         r, g, done_at;

  initial begin
    n_tests    = 0;
    n_fail     = 0;
    rst        = 1'b1;
    msg_clear  = 1'b0;
    rd_addr    = '0;
    rx.RxReady = 1'b0;
    rx.RxData  = 8'h00;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_value("rst_ack",  32'(rx.RxAck), 32'd0);
    check_value("rst_done", 32'(msg_done), 32'd0);
    check_value("rst_len",  32'(msg_len),  32'd0);
    check_value("rst_ovf",  32'(overflow), 32'd0);
    check_value("rst_to",   32'(timed_out), 32'd0);
    check_value("rst_rd",   32'(rd_data),  32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Case 1: "HI\r"
    send_byte(8'h48);
    send_byte(8'h49);
    check_value("hi_done_early", 32'(msg_done), 32'd0);
    send_byte(8'h0D);
    check_value("hi_done", 32'(msg_done), 32'd1);
    check_value("hi_len",  32'(msg_len),  32'd3);
    check_value("hi_ovf",  32'(overflow), 32'd0);
    check_value("hi_to",   32'(timed_out), 32'd0);
    read_check("hi_rd0", 0, 8'h48);
    read_check("hi_rd1", 1, 8'h49);
    read_check("hi_rd2", 2, 8'h0D);

    // Case 2: backpressure while done, then pending byte after clear
    rx.RxReady = 1'b1;
    rx.RxData  = 8'h41;
    ack_seen   = 1'b0;
    repeat (10) begin
      @(negedge clk);
      ack_seen = ack_seen | rx.RxAck;
    end
    check_value("bp_ack", 32'(ack_seen), 32'd0);
    check_value("bp_len", 32'(msg_len),  32'd3);
    pulse_clear();
    check_value("clr_done", 32'(msg_done), 32'd0);
    check_value("clr_ack",  32'(rx.RxAck), 32'd0);
    send_byte(8'h41);
    check_value("pend_len", 32'(msg_len), 32'd1);
    read_check("pend_rd0", 0, 8'h41);

    // Case 6: MsgClear mid-message is ignored
    send_byte(8'h42);
    pulse_clear();
    check_value("midclr_len",  32'(msg_len),  32'd2);
    check_value("midclr_done", 32'(msg_done), 32'd0);

    // Case 5: Reset while in RX_ACK
    rx.RxReady = 1'b1;
    rx.RxData  = 8'h99;
    @(negedge clk);
    check_value("rack_pre", 32'(rx.RxAck), 32'd1);
    rst        = 1'b1;
    rx.RxReady = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    check_value("rack_ack", 32'(rx.RxAck), 32'd0);
    check_value("rack_len", 32'(msg_len),  32'd0);
    send_byte(8'h77);
    check_value("rack_len1", 32'(msg_len), 32'd1);
    read_check("rack_rd0", 0, 8'h77);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Case 3: full buffer, without and with a terminator in the last slot
    for (int i = 0; i < DEPTH; i++) send_byte(8'h55);
    check_value("full_done", 32'(msg_done), 32'd1);
    check_value("full_ovf",  32'(overflow), 32'd1);
    check_value("full_len",  32'(msg_len),  32'd16);
    pulse_clear();
    check_value("full_clr_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH - 1; i++) send_byte(8'h55);
    send_byte(TERM);
    check_value("fterm_done", 32'(msg_done), 32'd1);
    check_value("fterm_ovf",  32'(overflow), 32'd0);
    check_value("fterm_len",  32'(msg_len),  32'd16);
    read_check("fterm_rd15", 15, TERM);
    pulse_clear();

    // Case 4: idle timeout exactly TMO cycles after the return to idle
    send_byte(8'h31);
    send_byte(8'h32);
    done_at = 0;
    for (int k = 1; k <= TMO + 5 && done_at == 0; k++) begin
      @(negedge clk);
      if (msg_done) done_at = k;
    end
    check_value("tmo_cycles", 32'(done_at), 32'(TMO));
    check_value("tmo_flag",   32'(timed_out), 32'd1);
    check_value("tmo_len",    32'(msg_len),   32'd2);
    pulse_clear();
    check_value("tmo_clr", 32'(timed_out), 32'd0);
    repeat (100) @(negedge clk);
    check_value("empty_idle_done", 32'(msg_done), 32'd0);

    // Random messages against a byte-queue model
    for (int m = 0; m < 40; m++) begin
      exp_q.delete();
      m_done = 1'b0;
      m_ovf  = 1'b0;
      m_to   = 1'b0;
      while (!m_done) begin
        r = $urandom_range(0, 5);
        b = (r == 0) ? TERM : 8'($urandom_range(0, 255));
        send_byte(b);
        exp_q.push_back(b);
        if (b == TERM) m_done = 1'b1;
        else if (exp_q.size() == DEPTH) begin
          m_done = 1'b1;
          m_ovf  = 1'b1;
        end
        check_value("rnd_len",  32'(msg_len),  32'(exp_q.size()));
        check_value("rnd_done", 32'(msg_done), 32'(m_done));
        if (!m_done) begin
          r = $urandom_range(0, 11);
          if (r == 0)      g = TMO - 1;
          else if (r == 1) g = TMO;
          else if (r == 2) g = $urandom_range(TMO + 1, TMO + 8);
          else             g = $urandom_range(0, 3);
          repeat (g) @(negedge clk);
          if (g >= TMO) begin
            m_done = 1'b1;
            m_to   = 1'b1;
          end
          check_value("rnd_gap_done", 32'(msg_done), 32'(m_done));
        end
      end
      check_value("rnd_fin_len", 32'(msg_len),   32'(exp_q.size()));
      check_value("rnd_fin_ovf", 32'(overflow),  32'(m_ovf));
      check_value("rnd_fin_to",  32'(timed_out), 32'(m_to));
      for (int i = 0; i < exp_q.size(); i++) read_check("rnd_rd", i, exp_q[i]);
      pulse_clear();
      check_value("rnd_clr_len", 32'(msg_len), 32'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rx_driver.md
Name: rx_driver

Overview:
Receive-side companion to the UART transmit driver. Accepts bytes from the UART receiver over a four-phase RxReady/RxAck handshake and stores them in an internal byte buffer. A message closes on a terminator byte, on a full buffer, or on an inter-byte idle timeout. The buffer is then held and readable until the host releases it with MsgClear.

Parameters:
DEPTH_LOG2, 8, buffer address width; buffer holds DEPTH = 2**DEPTH_LOG2 bytes.
TERM_CHAR, 8'h0D, terminator byte; it is stored and counted.
TIMEOUT_CYCLES, 0, idle cycles after the last byte before a partial message closes; 0 disables the timeout. Width 16 bits.

Ports:
Clock  in  1  system clock; all logic on the rising edge.
Reset  in  1  synchronous, active-high.
RxReady  in  1  receiver holds a valid byte; stays high until RxAck is seen.
RxData  in  8  received byte; valid while RxReady=1.
RxAck  out  1  registered; high while the byte is being consumed.
MsgClear  in  1  single-cycle pulse; releases the buffer in RX_DONE only.
MsgDone  out  1  message complete; buffer frozen.
MsgLen  out  DEPTH_LOG2+1  bytes stored in the current message (0..DEPTH).
Overflow  out  1  sticky; buffer filled without a terminator.
TimedOut  out  1  sticky; message closed by the idle timeout.
RdAddr  in  DEPTH_LOG2  buffer read address.
RdData  out  8  registered read data, 1-cycle latency, readable in any state.

Behaviour:
- Reset (sampled at a rising edge) returns the block to RX_IDLE. On that edge: RxAck=0, MsgDone=0, MsgLen=0, Overflow=0, TimedOut=0, write pointer=0, idle counter=0, RdData=0. Buffer contents are not cleared.
- Reset during any state, including mid-handshake in RX_ACK, drops RxAck on the next edge and discards the partial message.
- Reset has priority over MsgClear and over all handshake inputs.
- RX_IDLE:
  - RxAck=0.
  - RxReady=1: write RxData to mem[WrPtr] on this edge, latch RxData into LastByte, RxAck<=1, go to RX_ACK, clear the idle counter.
  - RxReady=0 with MsgLen>0 and TIMEOUT_CYCLES!=0: idle counter increments each cycle. When it reaches TIMEOUT_CYCLES: TimedOut<=1, MsgDone<=1, go to RX_DONE.
  - Idle counter does not run while MsgLen=0.
- RX_ACK:
  - Hold RxAck=1 until RxReady is sampled 0.
  - On that edge: RxAck<=0, WrPtr<=WrPtr+1, MsgLen<=MsgLen+1.
  - Then, if LastByte==TERM_CHAR: MsgDone<=1, go to RX_DONE.
  - Else if the new MsgLen==DEPTH: Overflow<=1, MsgDone<=1, go to RX_DONE.
  - Else go to RX_IDLE.
  - If a terminator arrives as byte DEPTH, termination wins and Overflow stays 0.
- RX_DONE:
  - MsgDone=1; no writes occur.
  - RxReady is ignored and RxAck stays 0, which backpressures the receiver.
  - On MsgClear: WrPtr<=0, MsgLen<=0, MsgDone<=0, Overflow<=0, TimedOut<=0, go to RX_IDLE.
  - A byte already pending on RxReady is accepted at the earliest in the cycle after the return to RX_IDLE.
- MsgClear outside RX_DONE is ignored.
- WrPtr is DEPTH_LOG2 bits and never wraps into stored data; the transition to RX_DONE at full prevents this.
- Undefined state encodings go to RX_IDLE with all outputs at their reset values.
- Buffer is one write port plus one registered read port; it infers block RAM.

Test Plan:
1. Drive "HI\r" (0x48, 0x49, 0x0D) with a receiver model that holds RxReady until RxAck, then drops it. Required: MsgDone=1 on the edge after the third RxReady fall; MsgLen=3; Overflow=0; TimedOut=0; RdAddr 0/1/2 returns 0x48/0x49/0x0D one cycle after each address is applied.
2. After case 1, hold RxReady=1 with 0x41 for 10 cycles. Required: RxAck stays 0 and MsgLen stays 3. Pulse MsgClear: MsgDone=0, then 0x41 is stored at address 0 and MsgLen=1.
3. DEPTH_LOG2=4: send 16 bytes of 0x55. Required: MsgDone=1, Overflow=1, MsgLen=16. Repeat with byte 16 = 0x0D: Overflow=0.
4. TIMEOUT_CYCLES=20: send 0x31, 0x32, then keep RxReady low. Required: MsgDone and TimedOut rise exactly 20 cycles after returning to RX_IDLE; MsgLen=2. With MsgLen=0, 100 idle cycles leave MsgDone=0.
5. Assert Reset for one edge while in RX_ACK (RxAck=1). Required: next cycle RxAck=0, MsgLen=0, state RX_IDLE. The next full byte handshake stores at address 0.
6. Pulse MsgClear in RX_IDLE mid-message (MsgLen=2). Required: no effect; MsgLen stays 2.
